// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: valid/ready pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with log levels spread over PIPE_STAGES
module alu_shift_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  rs1_data_i,
  input  logic [SHIFT_WIDTH-1:0] shamt_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   err_o
);
  localparam int W = DATA_WIDTH;
  localparam int S = SHIFT_WIDTH;
  localparam int P = PIPE_STAGES;
  if ((W & (W - 1)) != 0 || W < 8 || P < 1 || P > S) begin : g_bad_params
    $fatal(1, "alu_shift_pipe: illegal DATA_WIDTH/PIPE_STAGES");
  end
  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) y[i] = x[W-1-i];
    return y;
  endfunction
  function automatic logic [W-1:0] lvl(input logic [W-1:0] x, input logic [S-1:0] a,
                                       input logic f, input logic r, input int k);
    logic [W-1:0] y;
    y = x;
    for (int i = 0; i < S; i++)
      if ((i * P) / S == k && a[i])
        y = r ? ((y << (1 << i)) | (y >> (W - (1 << i))))
              : ((y << (1 << i)) | (f ? ((W'(1) << (1 << i)) - W'(1)) : '0));
    return y;
  endfunction
  logic [P-1:0]        valid_q, valid_d, fill_q, fill_d, rot_q, rot_d, rev_q, rev_d, err_q, err_d;
  logic [P-1:0][W-1:0] data_q, data_d;
  logic [P-1:0][S-1:0] amt_q, amt_d;
  logic [P:0]          rdy;
  logic [P-1:0]        sv, sf, sr, sb, se;
  logic [P-1:0][W-1:0] sd;
  logic [P-1:0][S-1:0] sa;
  logic                unused_last;
  always_comb begin
    se[0] = op_i > 3'd4;
    sr[0] = op_i == 3'd3 || op_i == 3'd4;
    sb[0] = op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4;
    sf[0] = op_i == 3'd2 && rs1_data_i[W-1];
    sv[0] = in_valid_i;
    sa[0] = se[0] ? '0 : shamt_i;
    sd[0] = sb[0] ? rev(rs1_data_i) : rs1_data_i;
    for (int k = 0; k < P - 1; k++) begin
      sv[k+1] = valid_q[k];
      se[k+1] = err_q[k];
      sr[k+1] = rot_q[k];
      sb[k+1] = rev_q[k];
      sf[k+1] = fill_q[k];
      sa[k+1] = amt_q[k];
      sd[k+1] = data_q[k];
    end
    rdy[P] = out_ready_i;
    for (int k = P - 1; k >= 0; k--) rdy[k] = !valid_q[k] || rdy[k+1];
    for (int k = 0; k < P; k++) begin
      valid_d[k] = rdy[k] ? sv[k] : valid_q[k];
      data_d[k]  = (rdy[k] && sv[k]) ? lvl(sd[k], sa[k], sf[k], sr[k], k) : data_q[k];
      amt_d[k]   = (rdy[k] && sv[k]) ? sa[k] : amt_q[k];
      fill_d[k]  = (rdy[k] && sv[k]) ? sf[k] : fill_q[k];
      rot_d[k]   = (rdy[k] && sv[k]) ? sr[k] : rot_q[k];
      rev_d[k]   = (rdy[k] && sv[k]) ? sb[k] : rev_q[k];
      err_d[k]   = (rdy[k] && sv[k]) ? se[k] : err_q[k];
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      fill_q  <= '0;
      rot_q   <= '0;
      rev_q   <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
      rev_q   <= rev_d;
      err_q   <= err_d;
    end
  end
  assign in_ready_o  = rdy[0];
  assign out_valid_o = valid_q[P-1];
  assign result_o    = rev_q[P-1] ? rev(data_q[P-1]) : data_q[P-1];
  assign err_o       = err_q[P-1];
  assign unused_last = ^{amt_q[P-1], fill_q[P-1], rot_q[P-1]};
endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb_alu_shift_pipe: scoreboard bench for alu_shift_pipe at DATA_WIDTH=32, PIPE_STAGES=2
module tb_alu_shift_pipe;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        err_o;
  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  alu_shift_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rs1_data_i(rs1_data_i), .shamt_i(shamt_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {a, a};
    case (op)
      3'd0: return {1'b0, a << s};
      3'd1: return {1'b0, a >> s};
      3'd2: return {1'b0, 32'($signed(a) >>> s)};
      3'd3: return {1'b0, 32'((dbl << s) >> 32)};
      3'd4: return {1'b0, 32'(dbl >> s)};
      default: return {1'b1, a};
    endcase
  endfunction
  task automatic cyc(input logic iv, input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                     input logic ordy, output logic acc, output logic got, output logic ov,
                     output logic [31:0] res, output logic e);
    in_valid_i = iv;
    op_i = op;
    rs1_data_i = a;
    shamt_i = sh;
    out_ready_i = ordy;
    #1;
    acc = iv & in_ready_o;
    ov = out_valid_o;
    got = out_valid_o & ordy;
    res = result_o;
    e = err_o;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid_o !== 1'b0 || result_o !== 32'h0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b result=%h err=%b need 0/0/0", out_valid_o, result_o, err_o);
    end
    rst_ni = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b need 1", in_ready_o);
    end
  endtask
  task automatic test_vectors();
    logic [2:0]  vop[7]  = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd7, 3'd2};
    logic [31:0] va[7]   = '{32'h1, 32'h8000_0010, 32'h8000_0010, 32'hF1, 32'h8000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [4:0]  vs[7]   = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd1, 5'd8, 5'd0};
    logic [31:0] vr[7]   = '{32'h8000_0000, 32'hF800_0001, 32'h0800_0001, 32'h1000_000F, 32'h3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic        ve[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic acc, got, ov, e;
    logic [31:0] res;
    int lat;
    for (int v = 0; v < 7; v++) begin
      cyc(1'b1, vop[v], va[v], vs[v], 1'b1, acc, got, ov, res, e);
      total++;
      if (!acc) begin
        bad++;
        $display("FAIL vec%0d_accept: accepted=%b need 1", v, acc);
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, acc, got, ov, res, e);
        lat++;
      end
      total++;
      if (lat !== 2 || !got) begin
        bad++;
        $display("FAIL vec%0d_latency: cycles=%0d seen=%b need 2", v, lat, got);
      end
      total++;
      if (res !== vr[v] || e !== ve[v]) begin
        bad++;
        $display("FAIL vec%0d_result: result=%h err=%b need %h/%b", v, res, e, vr[v], ve[v]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0]  bop[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [31:0] ba[4]  = '{32'h0000_00FF, 32'hF000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [4:0]  bs[4]  = '{5'd4, 5'd8, 5'd3, 5'd16};
    logic acc, got, ov, e;
    logic [31:0] res;
    logic [32:0] x;
    int sent, seen;
    sent = 0;
    seen = 0;
    exp_q.delete();
    for (int c = 0; c < 30 && seen < 4; c++) begin
      cyc(sent < 4, bop[sent % 4], ba[sent % 4], bs[sent % 4], c >= 3, acc, got, ov, res, e);
      if (acc) begin
        exp_q.push_back(model(bop[sent], ba[sent], bs[sent]));
        sent++;
      end
      if (c == 2) begin
        total++;
        if (acc !== 1'b0 || sent != 2) begin
          bad++;
          $display("FAIL b2b_full: accepted=%b count=%0d need 0/2", acc, sent);
        end
      end
      if (got) begin
        seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: result=%h with nothing expected", res);
        end else begin
          x = exp_q.pop_front();
          if ({e, res} !== x) begin
            bad++;
            $display("FAIL b2b_result: got %h/%b need %h/%b", res, e, x[31:0], x[32]);
          end
        end
      end
    end
    total++;
    if (seen != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: outputs=%0d left=%0d need 4/0", seen, exp_q.size());
    end
  endtask
  task automatic test_random();
    logic acc, got, ov, e, iv, ordy, pstall, pe;
    logic [31:0] res, a, pres;
    logic [2:0]  op;
    logic [4:0]  sh;
    logic [32:0] x;
    int c;
    exp_q.delete();
    pstall = 1'b0;
    pres = '0;
    pe = 1'b0;
    c = 0;
    while (c < 300 && (c < 200 || exp_q.size() != 0)) begin
      iv = c < 200 && $urandom_range(0, 3) != 0;
      ordy = c >= 200 || $urandom_range(0, 9) < 7;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      sh = 5'($urandom);
      cyc(iv, op, a, sh, ordy, acc, got, ov, res, e);
      if (pstall) begin
        total++;
        if (ov !== 1'b1 || res !== pres || e !== pe) begin
          bad++;
          $display("FAIL rnd_hold: valid=%b result=%h err=%b need 1/%h/%b", ov, res, e, pres, pe);
        end
      end
      pstall = ov & !ordy;
      pres = res;
      pe = e;
      if (acc) exp_q.push_back(model(op, a, sh));
      if (got) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra: result=%h with nothing expected", res);
        end else begin
          x = exp_q.pop_front();
          if ({e, res} !== x) begin
            bad++;
            $display("FAIL rnd_result: got %h/%b need %h/%b", res, e, x[31:0], x[32]);
          end
        end
      end
      c++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain: %0d results still outstanding need 0", exp_q.size());
    end
  endtask
  task automatic test_flush();
    logic acc0, acc1, got, ov, e;
    logic [31:0] res;
    int seen;
    cyc(1'b1, 3'd7, 32'h1234_5678, 5'd3, 1'b0, acc0, got, ov, res, e);
    cyc(1'b1, 3'd0, 32'h0000_0001, 5'd5, 1'b0, acc1, got, ov, res, e);
    total++;
    if (!acc0 || !acc1) begin
      bad++;
      $display("FAIL flush_fill: accepts=%b%b need 11", acc0, acc1);
    end
    rst_ni = 1'b0;
    cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, acc0, got, ov, res, e);
    rst_ni = 1'b1;
    total++;
    if (out_valid_o !== 1'b0 || result_o !== 32'h0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_state: valid=%b result=%h err=%b need 0/0/0", out_valid_o, result_o, err_o);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, acc0, got, ov, res, e);
      if (got) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_ghost: outputs after flush=%0d need 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
